// File: rtl/ac97_dmasched.sv
// AC97 DMA scheduler: one-word playback/capture buffers sharing one Wishbone master.
module ac97_dmasched (
  input  logic        sys_clk,
  input  logic        sys_rst,

  input  logic        dmar_en,
  input  logic [29:0] dmar_addr,
  input  logic [15:0] dmar_remaining,
  output logic        dmar_next,

  input  logic        dmaw_en,
  input  logic [29:0] dmaw_addr,
  input  logic [15:0] dmaw_remaining,
  output logic        dmaw_next,

  input  logic        down_en,
  input  logic        down_next_frame,
  output logic        down_pcm_valid,
  output logic [19:0] down_pcmleft,
  output logic [19:0] down_pcmright,
  output logic        down_underrun,

  input  logic        up_en,
  input  logic        up_next_frame,
  input  logic        up_frame_valid,
  input  logic        up_pcmleft_valid,
  input  logic [19:0] up_pcmleft,
  input  logic        up_pcmright_valid,
  input  logic [19:0] up_pcmright,
  output logic        up_overrun,

  output logic [31:0] wbm_adr_o,
  output logic [2:0]  wbm_cti_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q, state_d;
  logic        last_write_q, last_write_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;

  logic [31:0] dbuf_q;
  logic        dbuf_valid_q;
  logic [31:0] ubuf_q;
  logic        ubuf_valid_q;

  logic read_pend, write_pend, read_ack, write_ack;
  logic down_frame, up_capture, up_enabled, ubuf_free;
  logic unused_lsbs;

  assign read_pend  = dmar_en & (dmar_remaining != 16'd0) & ~dbuf_valid_q;
  assign write_pend = ubuf_valid_q;
  assign read_ack   = (state_q == StRead) & wbm_ack_i;
  assign write_ack  = (state_q == StWrite) & wbm_ack_i;

  assign down_frame = down_en & down_next_frame;
  assign up_capture = up_en & up_next_frame & up_frame_valid & up_pcmleft_valid &
                      up_pcmright_valid;
  assign up_enabled = dmaw_en & (dmaw_remaining != 16'd0);
  // A write completing this cycle frees the buffer for a simultaneous sample.
  assign ubuf_free  = ~ubuf_valid_q | write_ack;

  // The 4 LSBs of each 20-bit slot carry no sample data.
  assign unused_lsbs = ^{up_pcmleft[3:0], up_pcmright[3:0]};

  assign dmar_next = read_ack;
  assign dmaw_next = write_ack;

  assign wbm_adr_o = adr_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_sel_o = 4'b1111;
  assign wbm_dat_o = ubuf_q;

  // Bus FSM state and registered Wishbone request.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      last_write_q <= 1'b1;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_write_q <= last_write_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
    end
  end

  // Arbitration: alternate on contention, otherwise serve whichever side is pending.
  always_comb begin
    state_d      = state_q;
    last_write_d = last_write_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    unique case (state_q)
      StIdle: begin
        if (read_pend && (!write_pend || last_write_q)) begin
          state_d      = StRead;
          last_write_d = 1'b0;
          cyc_d        = 1'b1;
          we_d         = 1'b0;
          adr_d        = {dmar_addr, 2'b00};
        end else if (write_pend) begin
          state_d      = StWrite;
          last_write_d = 1'b1;
          cyc_d        = 1'b1;
          we_d         = 1'b1;
          adr_d        = {dmaw_addr, 2'b00};
        end
      end
      StRead, StWrite: begin
        if (wbm_ack_i) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // Playback word buffer: filled by a read ack, drained by a frame or by disabling DMA.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dbuf_q       <= 32'd0;
      dbuf_valid_q <= 1'b0;
    end else if (read_ack) begin
      dbuf_q       <= wbm_dat_i;
      dbuf_valid_q <= 1'b1;
    end else if (down_frame && dbuf_valid_q) begin
      dbuf_valid_q <= 1'b0;
    end else if (!dmar_en && state_q != StRead) begin
      dbuf_valid_q <= 1'b0;
    end
  end

  // Downstream slot outputs, updated once per requested frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      down_pcm_valid <= 1'b0;
      down_pcmleft   <= 20'd0;
      down_pcmright  <= 20'd0;
      down_underrun  <= 1'b0;
    end else begin
      down_underrun <= 1'b0;
      if (down_frame) begin
        if (dbuf_valid_q) begin
          down_pcm_valid <= 1'b1;
          down_pcmleft   <= {dbuf_q[31:16], 4'd0};
          down_pcmright  <= {dbuf_q[15:0], 4'd0};
        end else begin
          down_pcm_valid <= 1'b0;
          down_pcmleft   <= 20'd0;
          down_pcmright  <= 20'd0;
          down_underrun  <= dmar_en & (dmar_remaining != 16'd0);
        end
      end
    end
  end

  // Capture word buffer: loaded from a valid received frame, drained by a write ack.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ubuf_q       <= 32'd0;
      ubuf_valid_q <= 1'b0;
      up_overrun   <= 1'b0;
    end else begin
      up_overrun <= 1'b0;
      if (up_capture && up_enabled && ubuf_free) begin
        ubuf_q       <= {up_pcmleft[19:4], up_pcmright[19:4]};
        ubuf_valid_q <= 1'b1;
      end else begin
        if (write_ack) ubuf_valid_q <= 1'b0;
        if (up_capture && up_enabled) up_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ac97_dmasched.sv
// Self-checking bench for ac97_dmasched: directed scenarios plus a randomized run
// scored against a queue-based model of the two buffers and the bus arbiter.
module tb_ac97_dmasched;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        dmar_en, dmar_next, dmaw_en, dmaw_next;
  logic [29:0] dmar_addr, dmaw_addr;
  logic [15:0] dmar_remaining, dmaw_remaining;
  logic        down_en, down_next_frame, down_pcm_valid, down_underrun;
  logic [19:0] down_pcmleft, down_pcmright;
  logic        up_en, up_next_frame, up_frame_valid, up_pcmleft_valid, up_pcmright_valid;
  logic [19:0] up_pcmleft, up_pcmright;
  logic        up_overrun;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [2:0]  wbm_cti_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  ac97_dmasched dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .dmar_en           (dmar_en),
    .dmar_addr         (dmar_addr),
    .dmar_remaining    (dmar_remaining),
    .dmar_next         (dmar_next),
    .dmaw_en           (dmaw_en),
    .dmaw_addr         (dmaw_addr),
    .dmaw_remaining    (dmaw_remaining),
    .dmaw_next         (dmaw_next),
    .down_en           (down_en),
    .down_next_frame   (down_next_frame),
    .down_pcm_valid    (down_pcm_valid),
    .down_pcmleft      (down_pcmleft),
    .down_pcmright     (down_pcmright),
    .down_underrun     (down_underrun),
    .up_en             (up_en),
    .up_next_frame     (up_next_frame),
    .up_frame_valid    (up_frame_valid),
    .up_pcmleft_valid  (up_pcmleft_valid),
    .up_pcmleft        (up_pcmleft),
    .up_pcmright_valid (up_pcmright_valid),
    .up_pcmright       (up_pcmright),
    .up_overrun        (up_overrun),
    .wbm_adr_o         (wbm_adr_o),
    .wbm_cti_o         (wbm_cti_o),
    .wbm_we_o          (wbm_we_o),
    .wbm_cyc_o         (wbm_cyc_o),
    .wbm_stb_o         (wbm_stb_o),
    .wbm_sel_o         (wbm_sel_o),
    .wbm_dat_o         (wbm_dat_o),
    .wbm_dat_i         (wbm_dat_i),
    .wbm_ack_i         (wbm_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    dmar_en = 0; dmar_addr = 0; dmar_remaining = 0;
    dmaw_en = 0; dmaw_addr = 0; dmaw_remaining = 0;
    down_en = 0; down_next_frame = 0;
    up_en = 0; up_next_frame = 0; up_frame_valid = 0;
    up_pcmleft_valid = 0; up_pcmright_valid = 0; up_pcmleft = 0; up_pcmright = 0;
    wbm_dat_i = 0; wbm_ack_i = 0;
  endtask

  // Called #1 after a clock edge; leaves the bench #1 after an edge with reset released.
  task automatic do_reset();
    clear_inputs();
    sys_rst = 1;
    #1;
    check_eq("rst_cyc", {31'd0, wbm_cyc_o}, 0);
    check_eq("rst_stb", {31'd0, wbm_stb_o}, 0);
    check_eq("rst_adr", wbm_adr_o, 0);
    check_eq("rst_pcm_valid", {31'd0, down_pcm_valid}, 0);
    check_eq("rst_underrun", {31'd0, down_underrun}, 0);
    check_eq("rst_overrun", {31'd0, up_overrun}, 0);
    check_eq("rst_fixed", {25'd0, wbm_cti_o, wbm_sel_o}, 32'h0000000f);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 0;
  endtask

  task automatic wait_cyc(input string tag);
    for (int i = 0; i < 20 && !wbm_cyc_o; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check_eq(tag, {31'd0, wbm_cyc_o}, 1);
  endtask

  // Model state for the randomized run.
  logic [31:0] dq[$];  // playback words fetched but not yet played
  logic [31:0] cq[$];  // capture words accepted but not yet written
  logic exp_cyc, exp_we, last_w, exp_pv, exp_ur, exp_or;
  logic [19:0] exp_l, exp_r;
  logic rd_adv, wr_adv, rp, wp, rack, wack, ack, cap;
  logic [31:0] w;

  initial begin
    sys_rst = 1;
    clear_inputs();
    @(posedge sys_clk);
    #1;

    // Playback: one fetched word reaches the next frame.
    do_reset();
    dmar_en = 1; dmar_addr = 30'h100; dmar_remaining = 2;
    wait_cyc("play_req");
    check_eq("play_adr", wbm_adr_o, 32'h400);
    check_eq("play_we", {31'd0, wbm_we_o}, 0);
    wbm_ack_i = 1; wbm_dat_i = 32'h12345678;
    #1;
    check_eq("play_next", {31'd0, dmar_next}, 1);
    @(posedge sys_clk);
    #1;
    wbm_ack_i = 0; dmar_addr = 30'h101; dmar_remaining = 1;
    check_eq("play_cyc_drop", {31'd0, wbm_cyc_o}, 0);
    down_en = 1; down_next_frame = 1;
    @(posedge sys_clk);
    #1;
    down_next_frame = 0; dmar_en = 0;
    check_eq("play_valid", {31'd0, down_pcm_valid}, 1);
    check_eq("play_left", {12'd0, down_pcmleft}, 32'h12340);
    check_eq("play_right", {12'd0, down_pcmright}, 32'h56780);

    // Capture: one valid frame becomes one bus write.
    do_reset();
    dmaw_en = 1; dmaw_addr = 30'h200; dmaw_remaining = 1;
    up_en = 1; up_next_frame = 1; up_frame_valid = 1;
    up_pcmleft_valid = 1; up_pcmright_valid = 1;
    up_pcmleft = 20'hABCD0; up_pcmright = 20'h11110;
    @(posedge sys_clk);
    #1;
    up_next_frame = 0;
    wait_cyc("cap_req");
    check_eq("cap_adr", wbm_adr_o, 32'h800);
    check_eq("cap_we", {31'd0, wbm_we_o}, 1);
    check_eq("cap_dat", wbm_dat_o, 32'hABCD1111);
    wbm_ack_i = 1;
    #1;
    check_eq("cap_next", {31'd0, dmaw_next}, 1);
    @(posedge sys_clk);
    #1;
    wbm_ack_i = 0; dmaw_remaining = 0;
    check_eq("cap_cyc_drop", {31'd0, wbm_cyc_o}, 0);

    // Underrun on an empty buffer, then asynchronous reset during the read.
    do_reset();
    dmar_en = 1; dmar_addr = 30'h5; dmar_remaining = 5;
    down_en = 1; down_next_frame = 1;
    @(posedge sys_clk);
    #1;
    down_next_frame = 0;
    check_eq("ur_pulse", {31'd0, down_underrun}, 1);
    check_eq("ur_valid", {31'd0, down_pcm_valid}, 0);
    check_eq("ur_slots", {12'd0, down_pcmleft ^ down_pcmright}, 0);
    check_eq("ur_req_latency", {31'd0, wbm_cyc_o}, 1);
    @(posedge sys_clk);
    #1;
    check_eq("ur_one_cycle", {31'd0, down_underrun}, 0);
    wbm_ack_i = 1;
    #1;
    check_eq("arst_pre_next", {31'd0, dmar_next}, 1);
    sys_rst = 1;
    #1;
    check_eq("arst_cyc", {31'd0, wbm_cyc_o}, 0);
    check_eq("arst_stb", {31'd0, wbm_stb_o}, 0);
    check_eq("arst_next", {31'd0, dmar_next}, 0);
    wbm_ack_i = 0; dmar_en = 0;
    @(posedge sys_clk);
    #1;
    sys_rst = 0;
    @(posedge sys_clk);
    #1;
    check_eq("arst_idle", {31'd0, wbm_cyc_o}, 0);

    // Randomized traffic against the model.
    do_reset();
    dmar_en = 1; dmaw_en = 1; down_en = 1; up_en = 1;
    dq.delete(); cq.delete();
    exp_cyc = 0; exp_we = 0; last_w = 1; exp_pv = 0; exp_ur = 0; exp_or = 0;
    exp_l = 0; exp_r = 0; rd_adv = 0; wr_adv = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge sys_clk);
      #1;
      // Control interface reacts to last cycle's next pulses, and reloads idle channels.
      if (rd_adv) begin dmar_addr = dmar_addr + 1; dmar_remaining = dmar_remaining - 1; end
      if (wr_adv) begin dmaw_addr = dmaw_addr + 1; dmaw_remaining = dmaw_remaining - 1; end
      rd_adv = 0; wr_adv = 0;
      if (dmar_remaining == 0 && !(exp_cyc && !exp_we) && $urandom_range(0, 7) == 0) begin
        dmar_addr = 30'($urandom); dmar_remaining = 16'($urandom_range(1, 4));
      end
      if (dmaw_remaining == 0 && cq.size() == 0 && $urandom_range(0, 7) == 0) begin
        dmaw_addr = 30'($urandom); dmaw_remaining = 16'($urandom_range(1, 4));
      end
      ack = exp_cyc && ($urandom_range(0, 2) == 0);
      wbm_ack_i = ack;
      wbm_dat_i = $urandom;
      down_next_frame = ($urandom_range(0, 5) == 0);
      up_next_frame = ($urandom_range(0, 4) == 0);
      up_frame_valid = ($urandom_range(0, 7) != 0);
      up_pcmleft_valid = ($urandom_range(0, 7) != 0);
      up_pcmright_valid = ($urandom_range(0, 7) != 0);
      up_pcmleft = 20'($urandom);
      up_pcmright = 20'($urandom);
      #1;
      // Registered outputs from the previous edge.
      check_eq("rnd_cyc", {31'd0, wbm_cyc_o}, {31'd0, exp_cyc});
      check_eq("rnd_stb", {31'd0, wbm_stb_o}, {31'd0, exp_cyc});
      if (exp_cyc) check_eq("rnd_we", {31'd0, wbm_we_o}, {31'd0, exp_we});
      check_eq("rnd_pcm_valid", {31'd0, down_pcm_valid}, {31'd0, exp_pv});
      check_eq("rnd_pcm_left", {12'd0, down_pcmleft}, {12'd0, exp_l});
      check_eq("rnd_pcm_right", {12'd0, down_pcmright}, {12'd0, exp_r});
      check_eq("rnd_underrun", {31'd0, down_underrun}, {31'd0, exp_ur});
      check_eq("rnd_overrun", {31'd0, up_overrun}, {31'd0, exp_or});
      // Same-cycle handshake and next pulses.
      rack = exp_cyc && !exp_we && ack;
      wack = exp_cyc && exp_we && ack;
      check_eq("rnd_dmar_next", {31'd0, dmar_next}, {31'd0, rack});
      check_eq("rnd_dmaw_next", {31'd0, dmaw_next}, {31'd0, wack});
      if (rack) check_eq("rnd_rd_adr", wbm_adr_o, {dmar_addr, 2'b00});
      if (wack) begin
        check_eq("rnd_wr_adr", wbm_adr_o, {dmaw_addr, 2'b00});
        check_eq("rnd_wr_dat", wbm_dat_o, cq[0]);
      end
      // Pending as seen by the arbiter this cycle (before this cycle's buffer updates).
      rp = (dmar_remaining != 0) && (dq.size() == 0);
      wp = (cq.size() != 0);
      // Downstream frame: play the oldest fetched word, or report an underrun.
      exp_ur = 0;
      if (down_next_frame) begin
        if (dq.size() > 0) begin
          w = dq.pop_front();
          exp_pv = 1; exp_l = {w[31:16], 4'd0}; exp_r = {w[15:0], 4'd0};
        end else begin
          exp_pv = 0; exp_l = 0; exp_r = 0;
          exp_ur = (dmar_remaining != 0);
        end
      end
      // Upstream frame: one-word buffer, a completing write frees it.
      exp_or = 0;
      if (wack) begin
        void'(cq.pop_front());
        wr_adv = 1;
      end
      cap = up_next_frame && up_frame_valid && up_pcmleft_valid && up_pcmright_valid;
      if (cap && dmaw_remaining != 0) begin
        if (cq.size() == 0) cq.push_back({up_pcmleft[19:4], up_pcmright[19:4]});
        else exp_or = 1;
      end
      if (rack) begin
        dq.push_back(wbm_dat_i);
        rd_adv = 1;
      end
      // Bus for the next cycle.
      if (exp_cyc) begin
        if (ack) exp_cyc = 0;
      end else if (rp || wp) begin
        exp_we = (rp && wp) ? !last_w : wp;
        exp_cyc = 1;
        last_w = exp_we;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
